// File: rtl/ratio_sin_pkg.sv
// Shared defaults, FSM encoding and width helper for the ratio/sine engine.
package ratio_sin_pkg;
   localparam int W_DEF    = 12;
   localparam int NIN_DEF  = 3;
   localparam int FRAC_DEF = 14;
   localparam int PW_DEF   = 10;
   localparam int SW_DEF   = 14;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_OUT} state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing floor((num << (QW-1)) / den), one quotient bit per cycle.
module seq_divider
   import ratio_sin_pkg::*;
#(
   parameter int NW = 12,
   parameter int DW = 14,
   parameter int QW = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [NW-1:0] num_i,
   input  logic [DW-1:0] den_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [QW-1:0] quot_o,
   output logic          div_zero_o
);
   localparam int CW = (clog2(QW) > 0) ? clog2(QW) : 1;

   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] rem_q, rem_d, den_q;
   logic [QW-1:0] quot_q;
   logic          lsb_q, zero_q, bit_in, ge, load, last;
   logic [DW:0]   trial;

   assign load = start_i && !busy_q;
   assign last = busy_q && (cnt_q == CW'(QW - 1));

   // Quotient bits above QW-1 are always zero, so the remainder starts at num>>1
   // and only num[0] followed by zeros remains to be brought down.
   always_comb begin
      bit_in = (cnt_q == '0) ? lsb_q : 1'b0;
      trial  = {rem_q, bit_in};
      ge     = trial >= {1'b0, den_q};
      rem_d  = ge ? DW'(trial - {1'b0, den_q}) : trial[DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (load) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + 1'b1;
         if (last) busy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         rem_q  <= DW'(num_i >> 1);
         lsb_q  <= num_i[0];
         den_q  <= den_i;
         zero_q <= (den_i == '0);
         quot_q <= '0;
      end else if (busy_q) begin
         rem_q  <= rem_d;
         quot_q <= QW'({quot_q, ge});
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = last;
   assign quot_o     = zero_q ? '0 : quot_q;
   assign div_zero_o = zero_q;
endmodule

// File: rtl/ratio_sin_engine.sv
// Computes (operand0 / sum of operands) scaled by sin(serially captured phase).
module ratio_sin_engine
   import ratio_sin_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int NIN  = NIN_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int PW   = PW_DEF,
   parameter int SW   = SW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NIN*W-1:0]       in_data,
   input  logic                   ser_valid,
   input  logic                   ser_bit,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [FRAC+SW:0] y,
   output logic                   div_zero
);
   localparam int SUMW = W + clog2(NIN);
   localparam int QW   = FRAC + 1;
   localparam int YW   = FRAC + 1 + SW;
   localparam int CW   = (clog2(PW) > 0) ? clog2(PW) : 1;

   function automatic logic signed [SW-1:0] sin_val(input int p);
      real a, s;
      a = 2.0 * 3.14159265358979323846 * real'(p) / real'(2 ** PW);
      s = $sin(a) * real'((2 ** (SW - 1)) - 1);
      return SW'($rtoi((s < 0.0) ? s - 0.5 : s + 0.5));
   endfunction

   logic signed [SW-1:0] sin_rom [2**PW];
   for (genvar g = 0; g < 2**PW; g++) begin : g_rom
      localparam logic signed [SW-1:0] V = sin_val(g);
      assign sin_rom[g] = V;
   end

   state_e               state_q, state_d;
   logic [W-1:0]         op_q [NIN];
   logic [PW-1:0]        ph_q, sr_q, phase_q;
   logic [CW-1:0]        bc_q;
   logic                 frame_q, accept;
   logic [SUMW-1:0]      sum;
   logic                 div_start, div_busy, div_done, div_zero_w;
   logic [QW-1:0]        quot;
   logic signed [QW:0]   ratio_s;
   logic signed [SW-1:0] sine;
   logic signed [YW-1:0] prod, y_q;
   logic                 dz_q;

   assign accept = in_valid && in_ready;

   // Serial phase capture; the completed frame lands in phase_q one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q    <= '0;
         bc_q    <= '0;
         frame_q <= 1'b0;
         phase_q <= '0;
      end else begin
         frame_q <= ser_valid && (bc_q == CW'(PW - 1));
         if (ser_valid) begin
            sr_q <= PW'({sr_q, ser_bit});
            bc_q <= (bc_q == CW'(PW - 1)) ? '0 : bc_q + 1'b1;
         end
         if (frame_q) phase_q <= sr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NIN; k++) op_q[k] <= in_data[k*W +: W];
         ph_q <= phase_q;
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < NIN; k++) sum = sum + SUMW'(op_q[k]);
   end

   seq_divider #(.NW(W), .DW(SUMW), .QW(QW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start_i   (div_start),
      .num_i     (op_q[0]),
      .den_i     (sum),
      .busy_o    (div_busy),
      .done_o    (div_done),
      .quot_o    (quot),
      .div_zero_o(div_zero_w)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      div_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_DIV;
         end
         S_DIV: begin
            div_start = !div_busy;
            if (div_done) state_d = S_MUL;
         end
         S_MUL: state_d = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ratio is zero-extended so 2^FRAC stays positive; the product always fits YW bits.
   assign sine    = sin_rom[ph_q];
   assign ratio_s = $signed({1'b0, quot});
   assign prod    = YW'(ratio_s) * YW'(sine);

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q  <= '0;
         dz_q <= 1'b0;
      end else if (state_q == S_MUL) begin
         y_q  <= prod;
         dz_q <= div_zero_w;
      end
   end

   assign y        = y_q;
   assign div_zero = dz_q;
endmodule

// File: tb/tb_ratio_sin_engine.sv
// Self-checking bench: fixed vectors, corner sequences and random sets against a real-arithmetic model.
module tb_ratio_sin_engine;
   localparam int W = 12, NIN = 3, FRAC = 14, PW = 10, SW = 14, YW = FRAC + 1 + SW;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, ser_valid, ser_bit, out_valid, out_ready, div_zero;
   logic [NIN*W-1:0] in_data;
   logic signed [YW-1:0] y;

   int n_tests = 0, n_fail = 0;
   int cur_phase = 0;

   always #5 clk = ~clk;

   ratio_sin_engine #(.W(W), .NIN(NIN), .FRAC(FRAC), .PW(PW), .SW(SW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ser_valid(ser_valid), .ser_bit(ser_bit), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .div_zero(div_zero)
   );

   typedef struct {
      int     a;
      int     b;
      int     c;
      int     ph;
      longint ey;
      bit     edz;
   } vec_t;
   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   function automatic longint model_y(input int a, input int b, input int c, input int ph,
                                      output bit dz);
      int     sum;
      longint ratio, sine;
      real    s;
      sum   = a + b + c;
      dz    = (sum == 0);
      ratio = dz ? 0 : (longint'(a) << FRAC) / sum;
      s     = $sin(2.0 * 3.14159265358979323846 * real'(ph) / 1024.0) * 8191.0;
      sine  = longint'($rtoi($floor(s + 0.5)));
      return ratio * sine;
   endfunction

   // Sends bit positions lo..hi-1 (position 0 is the MSB) of v.
   task automatic send_bits(input logic [PW-1:0] v, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         ser_valid = 1'b1;
         ser_bit   = v[PW-1-i];
         tick();
      end
      ser_valid = 1'b0;
   endtask

   task automatic send_phase(input int p);
      send_bits(PW'(p), 0, PW);
      tick();
      cur_phase = p;
   endtask

   task automatic start_op(input int a, input int b, input int c, input bit sv, input bit sb);
      in_data   = {W'(c), W'(b), W'(a)};
      in_valid  = 1'b1;
      ser_valid = sv;
      ser_bit   = sb;
      chk("accept_ready", longint'(in_ready), 1);
      tick();
      in_valid  = 1'b0;
      ser_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_op(input string nm, input longint ey, input bit edz);
      int lat;
      wait_valid(lat);
      chk({nm, "_lat"}, lat, 17);
      chk({nm, "_y"}, longint'(y), ey);
      chk({nm, "_dz"}, longint'(div_zero), longint'(edz));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_idle"}, longint'({out_valid, in_ready}), 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0;
      out_ready = 1'b0; in_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_y", longint'(y), 0);
      chk("rst_dz", longint'(div_zero), 0);

      vecs[0] = '{4095, 0, 0, 0, 0, 1'b0};
      vecs[1] = '{1024, 1024, 2048, 256, 33550336, 1'b0};
      vecs[2] = '{4095, 0, 0, 768, -134201344, 1'b0};
      vecs[3] = '{0, 0, 0, 768, 0, 1'b1};
      vecs[4] = '{4095, 4095, 4095, 256, 44731051, 1'b0};
      vecs[5] = '{0, 5, 7, 256, 0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].ph != cur_phase) send_phase(vecs[i].ph);
         start_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0);
         finish_op($sformatf("vec%0d", i), vecs[i].ey, vecs[i].edz);
      end

      // Backpressure: result held, new requests ignored while out_ready is low.
      begin
         int lat;
         start_op(1024, 1024, 2048, 1'b0, 1'b0);
         wait_valid(lat);
         chk("bp_lat", lat, 17);
         in_valid = 1'b1;
         in_data  = {12'd1, 12'd2, 12'd3};
         for (int i = 0; i < 5; i++) begin
            chk("bp_y", longint'(y), 33550336);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_valid", longint'(out_valid), 1);
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("bp_consumed", longint'({out_valid, in_ready}), 1);
      end

      // Reset in the middle of a division aborts it.
      begin
         int seen;
         start_op(4095, 0, 0, 1'b0, 1'b0);
         repeat (5) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         cur_phase = 0;
         chk("abort_in_ready", longint'(in_ready), 1);
         seen = 0;
         for (int i = 0; i < 30; i++) begin
            if (out_valid) seen++;
            tick();
         end
         chk("abort_no_output", seen, 0);
      end

      // Reset mid-frame discards bits; phase needs a full new frame.
      send_bits(PW'(768), 0, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send_bits(PW'(256), 0, 9);
      tick();
      start_op(4095, 0, 0, 1'b0, 1'b0);
      finish_op("partial_frame", 0, 1'b0);
      send_bits(PW'(256), 9, 10);
      tick();
      cur_phase = 256;
      start_op(4095, 0, 0, 1'b0, 1'b0);
      finish_op("full_frame", 134201344, 1'b0);

      // Frame completing on the accept edge: old phase now, new phase next time.
      begin
         logic [PW-1:0] nv;
         nv = PW'(768);
         send_bits(nv, 0, 9);
         start_op(4095, 0, 0, 1'b1, nv[0]);
         finish_op("coincide_old", 134201344, 1'b0);
         cur_phase = 768;
         start_op(4095, 0, 0, 1'b0, 1'b0);
         finish_op("coincide_new", -134201344, 1'b0);
      end

      for (int i = 0; i < 25; i++) begin
         int a, b, c, ph;
         bit dz;
         longint ey;
         if ($urandom_range(0, 7) == 0) begin
            a = 0; b = 0; c = 0;
         end else begin
            a = $urandom_range(0, 4095);
            b = $urandom_range(0, 4095);
            c = $urandom_range(0, 4095);
         end
         ph = $urandom_range(0, 1023);
         send_phase(ph);
         ey = model_y(a, b, c, cur_phase, dz);
         start_op(a, b, c, 1'b0, 1'b0);
         finish_op($sformatf("rand%0d", i), ey, dz);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ratio_sin_engine.md
RATIO_SIN_ENGINE -- requirements
Module: ratio_sin_engine

Interface
REQ-001 SHALL have parameter W, 12, width of each operand.
REQ-002 SHALL have parameter NIN, 3, number of summed operands (NIN >= 1).
REQ-003 SHALL have parameter FRAC, 14, fractional bits of ratio.
REQ-004 SHALL have parameter PW, 10, phase width.
REQ-005 SHALL have parameter SW, 14, signed sine width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_valid  input  1  operand set valid.
REQ-009 SHALL have port in_ready  output  1  engine can accept operands.
REQ-010 SHALL have port in_data  input  NIN*W  operands; operand k = in_data[k*W +: W], unsigned; operand 0 is the numerator.
REQ-011 SHALL have port ser_valid  input  1  serial phase bit valid.
REQ-012 SHALL have port ser_bit  input  1  serial phase bit, MSB first.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port y  output  FRAC+1+SW  signed result.
REQ-016 SHALL have port div_zero  output  1  result came from a zero sum; qualified by out_valid.

Function
REQ-017 SHALL compute sum = sum of all NIN operands at width W+clog2(NIN), with no overflow.
REQ-018 SHALL compute ratio = floor((operand0 << FRAC) / sum) as unsigned FRAC+1 bits; ratio <= 2^FRAC always.
REQ-019 SHALL use ratio = 0 and div_zero = 1 when sum == 0.
REQ-020 SHALL shift ser_bit into a PW-bit shift register on each ser_valid, using a bit counter 0..PW-1 that wraps to 0.
REQ-021 SHALL copy the shift register to phase_reg on the cycle after the PW-th bit is taken; phase_reg resets to 0.
REQ-022 SHALL define sine = round(sin(2*pi*phase/2^PW) * (2^(SW-1)-1)) as SW-bit two's complement, from a combinational table.
REQ-023 SHALL produce y = signed(ratio) * sine at full FRAC+1+SW width, with no truncation.
REQ-024 SHALL run the FSM IDLE -> DIV -> MUL -> OUT -> IDLE.
REQ-025 In IDLE, SHALL drive in_ready = 1; in_valid && in_ready latches in_data and the current phase_reg, then moves to DIV.
REQ-026 In DIV, SHALL run a restoring divider, one quotient bit per cycle for FRAC+1 cycles, then move to MUL.
REQ-027 In MUL, SHALL register the product in y and div_zero, then move to OUT.
REQ-028 In OUT, SHALL hold out_valid = 1 with y and div_zero stable until out_ready; out_valid && out_ready moves to IDLE.
REQ-029 Latency: accept at edge T gives out_valid = 1 from cycle T+FRAC+3; throughput is at most one result per FRAC+4 cycles.
REQ-030 SHALL drive in_ready = 0 in every state except IDLE.
REQ-031 Serial capture SHALL run independently of the FSM in every state.
REQ-032 A phase update coinciding with acceptance SHALL leave the accepted set with the old phase_reg.
REQ-033 If no phase frame has completed, acceptance SHALL use phase 0.

Reset
REQ-034 rst SHALL force state IDLE, in_ready = 1 (first cycle after release), out_valid = 0, y = 0, div_zero = 0, bit counter = 0, shift register = 0, phase_reg = 0.
REQ-035 rst asserted mid-DIV, MUL or OUT SHALL abort the operation and produce no output.
REQ-036 rst asserted mid-frame SHALL discard the partial serial bits.

Structure
REQ-037 Package ratio_sin_pkg SHALL hold parameter defaults, FSM state encoding and a width helper (clog2).
REQ-038 The iterative divider SHALL be the single sub-module seq_divider (start, busy/done, quotient, div_zero).
REQ-039 The sine table and multiplier SHALL be inline in ratio_sin_engine.

Verification (defaults)
REQ-040 Operands 1024/1024/2048 with phase 256 SHALL give ratio 4096, sine 8191, y = 33550336, first out_valid exactly 17 cycles after the accept edge.
REQ-041 Operands 4095/0/0: phase 768 SHALL give y = -134201344; phase 0 SHALL give y = 0.
REQ-042 Operands 0/0/0 SHALL give y = 0 with div_zero = 1.
REQ-043 With out_ready held low for 5 cycles, y SHALL stay stable, in_ready SHALL stay 0, and a new in_valid SHALL NOT be accepted; the result SHALL be consumed on the cycle out_ready rises.
REQ-044 rst pulsed mid-DIV SHALL give no out_valid, in_ready = 1 next cycle, and a full 10-bit frame needed before phase_reg changes.
REQ-045 Completing a phase frame on the accept cycle SHALL make that result use the previous phase and the next result use the new one.
